memory_result_top: RTL
======================

// Module: memory_result_top
// PURPOSE
//  Write-side counterpart of the kernel-read path. Accepts one parallel result vector of up to MaxWidth
//  elements (e.g. a PE-row output) and serialises it, one element per cycle, into a local buffer at
//  consecutive addresses from startAddr. A host read port drains the buffer. Sits between the compute
//  array outputs and the host / next-layer memory.
// PARAMETERS
//  MaxWidth   9    max elements per result vector
//  Depth      32   buffer entries
//  DataWidth  8    bits per element
//  AddrWidth  $clog2(Depth) (localparam, not overridable)
// PORTS
//  clk          in   1                    single clock, all logic on rising edge
//  rst          in   1                    asynchronous, active-low reset
//  storeEn      in   1                    start pulse; samples dataIn/startAddr/outputWidth
//  startAddr    in   AddrWidth            buffer address of element 0
//  outputWidth  in   AddrWidth            elements to store (0..MaxWidth; larger clamped to MaxWidth)
//  dataIn       in   MaxWidth*DataWidth   result vector; element i = dataIn[i*DataWidth +: DataWidth]
//  readEn       in   1                    host read strobe
//  readAddr     in   AddrWidth            host read address
//  dataOut      out  DataWidth            host read data
//  busy         out  1                    high in WRITE
//  finished     out  1                    one-cycle done pulse
//  state        out  4                    FSM state code (debug)
//  lastWriteAddr out AddrWidth            address of the last element written
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, busy=0, finished=0, dataOut=0, lastWriteAddr=0, index=0.
//   Buffer contents are NOT cleared. Reset mid-WRITE aborts; already-written entries remain.
//  FSM (state codes): IDLE=0, WRITE=1, DONE=2.
//   IDLE: storeEn=1 -> latch dataIn, startAddr, clamped width into shadow regs; width=0 -> DONE,
//         else WRITE with index=0. dataIn may change freely after the sampling edge.
//   WRITE: each cycle write element[index] to addr=(startAddrReg+index) mod Depth (wrap past Depth-1
//          to 0); lastWriteAddr updated to that addr; index++. Write of index==width-1 -> DONE.
//   DONE: finished=1 for exactly this cycle; -> IDLE unconditionally.
//  Latency: storeEn at edge N -> first write at edge N+1, last write at edge N+width, finished high in
//   the cycle after the last write; total width+2 cycles storeEn-to-IDLE. Width 0: finished 1 cycle later.
//  storeEn while WRITE/DONE is ignored (no queueing). storeEn held high re-triggers on each IDLE visit.
//  Address arithmetic in AddrWidth bits, wrap is natural modulo; width counter compares on AddrWidth.
//  Host read: readEn at edge N -> dataOut valid after edge N (1-cycle registered); dataOut holds when
//   readEn=0. Reads allowed in any state. Same-cycle read/write to the same address returns OLD data.
//  If Depth is not a power of two, wrap is still modulo 2^AddrWidth; Depth must be a power of two.
// STRUCTURE
//  Package memory_result_pkg: state encodings (IDLE/WRITE/DONE), default MaxWidth/Depth/DataWidth.
//  Sub-module router_writeback: FSM + shadow regs + index counter + element mux; outputs writeEn,
//   writeAddr, writeData, busy, finished, state, lastWriteAddr.
//  Storage: existing buffer module (Depth, DataWidth), writes from router_writeback, reads from host.
// TESTING
//  1 Basic: startAddr=4, width=9, dataIn elements 0x11..0x99 -> addrs 4..12 hold 0x11..0x99, finished
//    pulses once at cycle 10 after storeEn, lastWriteAddr=12; host reads 4..12 return same values.
//  2 Wrap: startAddr=30, width=5, elements 1..5 -> addrs 30,31,0,1,2 = 1..5, lastWriteAddr=2.
//  3 Edge widths: width=0 -> no buffer write, finished one cycle after storeEn; width=15 -> clamped,
//    exactly 9 writes; width=1 -> single write, busy high one cycle.
//  4 Busy-ignore + collision: second storeEn mid-WRITE ignored (contents from first only); host read of
//    address being written that cycle returns prior value, next read returns new value.
//  5 Reset mid-WRITE: assert rst after 3 of 9 writes -> outputs zero immediately, state=0, first 3
//    entries written, remaining addresses unchanged; new storeEn after release works normally.

Source files
------------

// File: rtl/memory_result_pkg.sv
// Shared state encodings and default sizing for the result write-back path.
package memory_result_pkg;

    localparam int MaxWidthDef  = 9;
    localparam int DepthDef     = 32;
    localparam int DataWidthDef = 8;

    localparam logic [3:0] StIdle  = 4'd0;
    localparam logic [3:0] StWrite = 4'd1;
    localparam logic [3:0] StDone  = 4'd2;

endpackage

// File: rtl/memory_result_buffer.sv
// Result buffer: one synchronous write port, one registered host read port.
// Latency: write lands on the clock edge; read data appears one cycle after readEn.
// Backpressure: none; a same-cycle read and write to one address returns the old data.
module memory_result_buffer #(
    parameter int Depth     = 32,
    parameter int DataWidth = 8,
    localparam int AddrWidth = $clog2(Depth)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 writeEn,
    input  logic [AddrWidth-1:0] writeAddr,
    input  logic [DataWidth-1:0] writeData,
    input  logic                 readEn,
    input  logic [AddrWidth-1:0] readAddr,
    output logic [DataWidth-1:0] dataOut
);

    // Storage is deliberately not reset so a reset mid-write keeps earlier entries.
    logic [DataWidth-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (writeEn) begin
            mem[writeAddr] <= writeData;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dataOut <= '0;
        end else if (readEn) begin
            dataOut <= mem[readAddr];
        end
    end

endmodule

// File: rtl/memory_result_router_writeback.sv
// Serialiser: latches a result vector and emits one buffer write per cycle from startAddr.
// Latency: first write one cycle after storeEn, finished pulses the cycle after the last write.
// Backpressure: none; storeEn outside IDLE is dropped, not queued.
module router_writeback
    import memory_result_pkg::*;
#(
    parameter int MaxWidth  = 9,
    parameter int DataWidth = 8,
    parameter int AddrWidth = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          storeEn,
    input  logic [AddrWidth-1:0]          startAddr,
    input  logic [AddrWidth-1:0]          outputWidth,
    input  logic [MaxWidth*DataWidth-1:0] dataIn,
    output logic                          writeEn,
    output logic [AddrWidth-1:0]          writeAddr,
    output logic [DataWidth-1:0]          writeData,
    output logic                          busy,
    output logic                          finished,
    output logic [3:0]                    state,
    output logic [AddrWidth-1:0]          lastWriteAddr
);

    localparam logic [AddrWidth-1:0] MaxWidthA = AddrWidth'(MaxWidth);

    logic [3:0]                    stateReg;
    logic [MaxWidth*DataWidth-1:0] dataReg;
    logic [AddrWidth-1:0]          startReg;
    logic [AddrWidth-1:0]          widthReg;
    logic [AddrWidth-1:0]          index;
    logic [AddrWidth-1:0]          clampedWidth;

    always_comb begin
        clampedWidth = (outputWidth > MaxWidthA) ? MaxWidthA : outputWidth;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateReg      <= StIdle;
            dataReg       <= '0;
            startReg      <= '0;
            widthReg      <= '0;
            index         <= '0;
            lastWriteAddr <= '0;
        end else begin
            case (stateReg)
                StIdle: begin
                    if (storeEn) begin
                        dataReg  <= dataIn;
                        startReg <= startAddr;
                        widthReg <= clampedWidth;
                        index    <= '0;
                        stateReg <= (clampedWidth == '0) ? StDone : StWrite;
                    end
                end
                StWrite: begin
                    lastWriteAddr <= writeAddr;
                    index         <= index + AddrWidth'(1);
                    if (index == widthReg - AddrWidth'(1)) begin
                        stateReg <= StDone;
                    end
                end
                StDone:  stateReg <= StIdle;
                default: stateReg <= StIdle;
            endcase
        end
    end

    // Address wraps modulo 2^AddrWidth through plain truncating addition.
    always_comb begin
        writeAddr = startReg + index;
        writeData = '0;
        for (int i = 0; i < MaxWidth; i++) begin
            if (index == AddrWidth'(i)) begin
                writeData = dataReg[i*DataWidth +: DataWidth];
            end
        end
    end

    assign writeEn  = (stateReg == StWrite);
    assign busy     = (stateReg == StWrite);
    assign finished = (stateReg == StDone);
    assign state    = stateReg;

endmodule

// File: rtl/memory_result_top.sv
// Result write-back: serialises a parallel result vector into a local buffer drained by the host.
// Latency: width+2 cycles storeEn-to-IDLE; host read data one cycle after readEn.
// Backpressure: none; storeEn is ignored while a store is in progress.
module memory_result_top
    import memory_result_pkg::*;
#(
    parameter int MaxWidth  = MaxWidthDef,
    parameter int Depth     = DepthDef,
    parameter int DataWidth = DataWidthDef,
    localparam int AddrWidth = $clog2(Depth)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          storeEn,
    input  logic [AddrWidth-1:0]          startAddr,
    input  logic [AddrWidth-1:0]          outputWidth,
    input  logic [MaxWidth*DataWidth-1:0] dataIn,
    input  logic                          readEn,
    input  logic [AddrWidth-1:0]          readAddr,
    output logic [DataWidth-1:0]          dataOut,
    output logic                          busy,
    output logic                          finished,
    output logic [3:0]                    state,
    output logic [AddrWidth-1:0]          lastWriteAddr
);

    logic                 writeEn;
    logic [AddrWidth-1:0] writeAddr;
    logic [DataWidth-1:0] writeData;

    router_writeback #(
        .MaxWidth  (MaxWidth),
        .DataWidth (DataWidth),
        .AddrWidth (AddrWidth)
    ) uWriteback (
        .clk           (clk),
        .rst           (rst),
        .storeEn       (storeEn),
        .startAddr     (startAddr),
        .outputWidth   (outputWidth),
        .dataIn        (dataIn),
        .writeEn       (writeEn),
        .writeAddr     (writeAddr),
        .writeData     (writeData),
        .busy          (busy),
        .finished      (finished),
        .state         (state),
        .lastWriteAddr (lastWriteAddr)
    );

    memory_result_buffer #(
        .Depth     (Depth),
        .DataWidth (DataWidth)
    ) uBuffer (
        .clk       (clk),
        .rst       (rst),
        .writeEn   (writeEn),
        .writeAddr (writeAddr),
        .writeData (writeData),
        .readEn    (readEn),
        .readAddr  (readAddr),
        .dataOut   (dataOut)
    );

endmodule
